mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- CPU-side sequencer that converts single core memory requests (valid/ready) into the multiplexed pin-level memory bus.
- Bus signals: one write-request strobe, one 15-bit request bus carrying address or write data, and an 8-bit read-data return.
- Sits between the CPU datapath and the chip pins that feed the external/behavioural SimpleMemory.
- Owns phase sequencing, the read-latency wait and response generation.

Parameters:
- ADDR_WIDTH, 15, width of the request bus and of the address. Must be >= DATA_WIDTH.
- DATA_WIDTH, 8, width of read and write data.
- READ_LATENCY, 1, cycles from the address-phase cycle to the cycle in which mem_read_data is valid. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request. Equals 1 exactly when the state is IDLE.
- req_we  in  1  1 = write, 0 = read. Sampled on acceptance.
- req_addr  in  ADDR_WIDTH  request address. Sampled on acceptance.
- req_wdata  in  DATA_WIDTH  write data. Sampled on acceptance.
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata  out  DATA_WIDTH  last read data. Holds its value until the next read completes.
- mem_write_req  out  1  bus write strobe (pin bit 7 of the uio group).
- mem_req_bus  out  ADDR_WIDTH  multiplexed address/data bus.
- mem_read_data  in  DATA_WIDTH  read data returned by memory.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - mem_write_req=0, mem_req_bus=0, rsp_valid=0, rsp_rdata=0, latched-address register=0.
  - req_ready=1 while in reset and after release.
- Registered outputs:
  - mem_write_req, mem_req_bus, rsp_valid and rsp_rdata come straight from flops, with no combinational path from core inputs.
  - req_ready is decoded from state only.
- Acceptance:
  - A request is accepted at the edge where req_valid && req_ready.
  - req_we, req_addr and req_wdata are latched at that edge. Inputs are don't-care at all other times.
- States: IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_DATA.
- Transitions:
  - IDLE -> RD_ADDR on an accepted read.
  - IDLE -> WR_ADDR on an accepted write.
  - RD_ADDR -> RD_WAIT.
  - RD_WAIT -> IDLE when the wait counter expires; otherwise stay in RD_WAIT.
  - WR_ADDR -> WR_DATA.
  - WR_DATA -> IDLE.
- Read timing (request accepted at the end of cycle T, latency L = READ_LATENCY):
  - Cycle T+1 (RD_ADDR): mem_req_bus=addr, mem_write_req=0.
  - Cycles T+2..T+1+L (RD_WAIT): bus holds addr, mem_write_req=0. A 4-bit counter loaded with L-1 counts down.
  - mem_read_data is sampled into rsp_rdata at the end of cycle T+1+L.
  - Cycle T+2+L: rsp_valid=1 and state is IDLE.
- Write timing (request accepted at the end of cycle T):
  - Cycle T+1 (WR_ADDR): mem_write_req=1, mem_req_bus=addr.
  - Cycle T+2 (WR_DATA): mem_write_req=1, mem_req_bus = zero-extended wdata (upper ADDR_WIDTH-DATA_WIDTH bits = 0). Memory commits in this phase.
  - Cycle T+3: mem_write_req=0, rsp_valid=1, state IDLE. rsp_rdata is unchanged.
- IDLE bus:
  - mem_write_req=0.
  - mem_req_bus holds the address of the last accepted request (0 after reset). It never holds write data, so no spurious write is possible and idle reads are harmless.
- Throughput:
  - Back-to-back acceptance is allowed in the IDLE cycle that carries rsp_valid.
  - Reads complete at most one per L+2 cycles; writes at most one per 3 cycles.
- Boundary conditions:
  - Request presented while busy: ignored (ready=0) and must be held by the core. No queueing.
  - Address 0x7FFF and address 0 are handled identically; there is no wrap logic.
  - mem_read_data is ignored in every state except the RD_WAIT sample edge.
- Reset mid-operation:
  - Aborts the transaction. No rsp_valid is issued.
  - mem_write_req drops to 0 asynchronously. A write interrupted before the end of WR_DATA may be lost.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> mem_write_req=0, mem_req_bus=0, rsp_valid=0, req_ready=1 for 10 idle cycles.
- Write, L=1: write addr=0x1234, data=0xA5 accepted at cycle T -> T+1: wr=1, bus=0x1234; T+2: wr=1, bus=0x00A5; T+3: rsp_valid=1, wr=0, bus=0x1234; memory location 0x1234 holds 0xA5.
- Read-back, L=1: read 0x1234 accepted at T -> T+1: bus=0x1234, wr=0; rsp_valid=1 with rsp_rdata=0xA5 at T+3; rsp_rdata is still 0xA5 20 cycles later.
- Back-to-back and extreme addresses: write 0x7FFF=0x3C immediately followed by read 0x7FFF and read 0x0000 (pre-loaded 0x11), req_valid held high -> each accepted in its rsp_valid IDLE cycle; reads return 0x3C then 0x11; ready=0 during every busy cycle.
- Latency parameter: READ_LATENCY=3 with a memory model delayed to match, read 0x0042 (=0x7E) accepted at T -> bus holds 0x0042 with wr=0 for T+1..T+4; rsp_valid at T+5 with rdata=0x7E; a garbage value on mem_read_data in T+2..T+3 does not affect the result.
- Reset mid-write: assert rst_n=0 during WR_DATA -> mem_write_req=0 immediately (asynchronously), no rsp_valid; after release a new read completes normally with the correct latency.

Source files
------------

// File: rtl/mem_bus_master.sv
// Sequences single core memory requests onto the multiplexed address/data memory bus.
// All bus and response outputs are registered; req_ready decodes from state alone.
module mem_bus_master #(
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_write_req,
  output logic [ADDR_WIDTH-1:0] mem_req_bus,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [3:0] CntInit = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdWait, StWrAddr, StWrData} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] bus_q, bus_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    bus_d       = bus_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          bus_d   = req_addr;
          if (req_we) begin
            wr_d    = 1'b1;
            state_d = StWrAddr;
          end else begin
            state_d = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        cnt_d   = CntInit;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == 4'd0) begin
          rdata_d     = mem_read_data;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrAddr: begin
        wr_d    = 1'b1;
        bus_d   = ADDR_WIDTH'(wdata_q);
        state_d = StWrData;
      end
      StWrData: begin
        // Restore the address so the idle bus never carries write data.
        bus_d       = addr_q;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      bus_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign mem_write_req = wr_q;
  assign mem_req_bus   = bus_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: one master with a behavioural memory (latency 1) and one latency-3
// master whose read data is driven by hand.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_we;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        mem_write_req;
  logic [14:0] mem_req_bus;
  logic [7:0]  mem_read_data;

  logic        req_valid3, req_ready3;
  logic [14:0] req_addr3;
  logic        rsp_valid3;
  logic [7:0]  rsp_rdata3;
  logic        mem_write_req3;
  logic [14:0] mem_req_bus3;
  logic [7:0]  mem_read_data3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_master #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .READ_LATENCY(1)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_write_req (mem_write_req),
    .mem_req_bus   (mem_req_bus),
    .mem_read_data (mem_read_data)
  );

  mem_bus_master #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .READ_LATENCY(3)) u_dut_l3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid3),
    .req_ready     (req_ready3),
    .req_we        (1'b0),
    .req_addr      (req_addr3),
    .req_wdata     (8'h00),
    .rsp_valid     (rsp_valid3),
    .rsp_rdata     (rsp_rdata3),
    .mem_write_req (mem_write_req3),
    .mem_req_bus   (mem_req_bus3),
    .mem_read_data (mem_read_data3)
  );

  // Behavioural memory: first strobed cycle is the address, second the data.
  logic [7:0]  mem [0:32767];
  logic        wr_phase;
  logic [14:0] wr_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_phase      <= 1'b0;
      wr_addr       <= '0;
      mem_read_data <= '0;
    end else begin
      mem_read_data <= mem[mem_req_bus];
      if (mem_write_req && !wr_phase) begin
        wr_addr  <= mem_req_bus;
        wr_phase <= 1'b1;
      end else if (mem_write_req && wr_phase) begin
        mem[wr_addr] <= mem_req_bus[7:0];
        wr_phase     <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back request table.
  logic        b2b_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [14:0] b2b_addr [4] = '{15'h0000, 15'h7FFF, 15'h7FFF, 15'h0000};
  logic [7:0]  b2b_data [4] = '{8'h11, 8'h3C, 8'h00, 8'h00};
  logic [7:0]  b2b_exp  [4] = '{8'h00, 8'h00, 8'h3C, 8'h11};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_valid3     = 1'b0;
    req_addr3      = '0;
    mem_read_data3 = '0;

    // Reset then idle
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_wr", mem_write_req, 0);
    check("rst_bus", mem_req_bus, 0);
    check("rst_rsp", rsp_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_wr", mem_write_req, 0);
      check("idle_bus", mem_req_bus, 0);
      check("idle_rsp", rsp_valid, 0);
      check("idle_ready", req_ready, 1);
    end

    // Write 0x1234 = 0xA5
    req_we = 1'b1; req_addr = 15'h1234; req_wdata = 8'hA5; req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_addr = 15'h5555; req_wdata = 8'hEE;
    check("wr_t1_wr", mem_write_req, 1);
    check("wr_t1_bus", mem_req_bus, 15'h1234);
    check("wr_t1_ready", req_ready, 0);
    step();
    check("wr_t2_wr", mem_write_req, 1);
    check("wr_t2_bus", mem_req_bus, 15'h00A5);
    check("wr_t2_rsp", rsp_valid, 0);
    step();
    check("wr_t3_rsp", rsp_valid, 1);
    check("wr_t3_wr", mem_write_req, 0);
    check("wr_t3_bus", mem_req_bus, 15'h1234);
    check("wr_t3_ready", req_ready, 1);
    check("wr_mem", mem[15'h1234], 8'hA5);
    check("wr_rdata_kept", rsp_rdata, 8'h00);

    // Read back 0x1234
    req_we = 1'b0; req_addr = 15'h1234; req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_addr = 15'h0777;
    check("rd_t1_bus", mem_req_bus, 15'h1234);
    check("rd_t1_wr", mem_write_req, 0);
    step();
    check("rd_t2_rsp", rsp_valid, 0);
    check("rd_t2_bus", mem_req_bus, 15'h1234);
    step();
    check("rd_t3_rsp", rsp_valid, 1);
    check("rd_t3_rdata", rsp_rdata, 8'hA5);
    repeat (20) step();
    check("rd_hold_rdata", rsp_rdata, 8'hA5);
    check("rd_hold_rsp", rsp_valid, 0);

    // Back-to-back with req_valid held high, extreme addresses
    req_we = b2b_we[0]; req_addr = b2b_addr[0]; req_wdata = b2b_data[0]; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin
        req_we = b2b_we[i+1]; req_addr = b2b_addr[i+1]; req_wdata = b2b_data[i+1];
      end else begin
        req_valid = 1'b0;
      end
      busy = 0;
      while (!req_ready && busy < 20) begin
        busy++;
        step();
      end
      check("b2b_busy", busy, 2);
      check("b2b_rsp", rsp_valid, 1);
      if (!b2b_we[i]) check("b2b_rdata", rsp_rdata, b2b_exp[i]);
    end

    // Latency 3 instance, garbage on read data before the sample cycle
    req_addr3 = 15'h0042; req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0; req_addr3 = 15'h1111;
    mem_read_data3 = 8'hFF;
    check("l3_t1_bus", mem_req_bus3, 15'h0042);
    check("l3_t1_wr", mem_write_req3, 0);
    step();
    mem_read_data3 = 8'hC3;
    check("l3_t2_bus", mem_req_bus3, 15'h0042);
    step();
    mem_read_data3 = 8'h5A;
    check("l3_t3_bus", mem_req_bus3, 15'h0042);
    check("l3_t3_rsp", rsp_valid3, 0);
    step();
    mem_read_data3 = 8'h7E;
    check("l3_t4_bus", mem_req_bus3, 15'h0042);
    check("l3_t4_wr", mem_write_req3, 0);
    check("l3_t4_rsp", rsp_valid3, 0);
    check("l3_t4_ready", req_ready3, 0);
    step();
    mem_read_data3 = 8'h00;
    check("l3_t5_rsp", rsp_valid3, 1);
    check("l3_t5_rdata", rsp_rdata3, 8'h7E);
    check("l3_t5_ready", req_ready3, 1);
    step();
    check("l3_t6_rsp", rsp_valid3, 0);

    // Reset asserted during WR_DATA
    req_we = 1'b1; req_addr = 15'h0100; req_wdata = 8'h99; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("mid_wrdata_wr", mem_write_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_async_wr", mem_write_req, 0);
    check("mid_async_ready", req_ready, 1);
    check("mid_async_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_rsp", rsp_valid, 0);
    end
    req_we = 1'b0; req_addr = 15'h7FFF; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("post_t1_bus", mem_req_bus, 15'h7FFF);
    step();
    check("post_t2_rsp", rsp_valid, 0);
    step();
    check("post_t3_rsp", rsp_valid, 1);
    check("post_t3_rdata", rsp_rdata, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
